dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data RAM between the CPU load/store path and a debug/loader port. It sits between the CPU datapath's RAM address/data/write-enable signals and the `ram` instance. It grants at most one requester per cycle and stalls the CPU (PC hold) when the CPU loses. It also keeps a saturating count of CPU stall cycles for the debug port.

## Interface
Parameters:
- `ADDR_W`, 10: RAM word-address width.
- `DATA_W`, 32: data width.
- `MAX_BURST`, 4: maximum consecutive locked debug grants while the CPU is waiting (≥1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: CPU needs RAM this cycle (load or store).
- `cpu_we` in 1: CPU store.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in DATA_W: CPU store data.
- `cpu_rdata` out DATA_W: CPU load data.
- `cpu_stall` out 1: CPU must hold PC and all architectural state this cycle.
- `dbg_req` in 1: debug access request.
- `dbg_we` in 1: debug write.
- `dbg_lock` in 1: debug requests burst retention.
- `dbg_addr` in ADDR_W: debug word address.
- `dbg_wdata` in DATA_W: debug write data.
- `dbg_rdata` out DATA_W: debug read data.
- `dbg_gnt` out 1: debug access performed this cycle.
- `ram_addr` out ADDR_W: to RAM.
- `ram_we` out 1: to RAM.
- `ram_din` out DATA_W: to RAM.
- `ram_dout` in DATA_W: from RAM (combinational read).
- `stall_cnt` out 16: saturating count of cycles with `cpu_stall`=1 while out of reset.

## Operation
- Registered state: `owner` ∈ {IDLE, CPU, DBG} (grant of previous cycle), `burst_cnt` (0..MAX_BURST), `stall_cnt`.
- Grant decision per cycle, combinational from inputs and registered state:
  - Only `cpu_req`: CPU granted.
  - Only `dbg_req`: DBG granted.
  - Neither: no grant. `ram_we`=0. Next `owner`=IDLE.
  - Both, `owner`=IDLE or CPU: DBG granted (round-robin).
  - Both, `owner`=DBG, `dbg_lock`=1, `burst_cnt`<MAX_BURST: DBG granted.
  - Both, `owner`=DBG otherwise: CPU granted.
- Grant outputs:
  - `cpu_stall` = `cpu_req` & ~CPU-granted.
  - `dbg_gnt` = DBG-granted.
- Mux: the granted port drives `ram_addr`/`ram_din`. `ram_we` = granted port's `we`. With no grant, `ram_addr`=`cpu_addr`, `ram_din`=`cpu_wdata`, `ram_we`=0.
- `cpu_rdata` and `dbg_rdata` both equal `ram_dout`. Each is valid only for its port's granted cycle.
- `burst_cnt`:
  - Increments on a DBG grant while `cpu_req`=1, saturating at MAX_BURST.
  - Resets to 0 on any CPU grant or idle cycle.
  - Holds on a DBG grant with `cpu_req`=0.
- `stall_cnt` increments each stalled cycle and saturates at 16'hFFFF.

## Timing
- Grant, stall, RAM mux and read data are zero-latency, same cycle.
- The RAM write commits on the `clk` rising edge of the granted cycle.
- A stalled CPU re-presents the same request. It is served no later than MAX_BURST+1 cycles after first contention.
- Reset (`rst_n`=0) behaviour:
  - `owner`=IDLE, `burst_cnt`=0, `stall_cnt`=0.
  - Outputs are forced: `ram_we`=0, `dbg_gnt`=0, `cpu_stall`=1 (PC frozen), `cpu_rdata`/`dbg_rdata`=`ram_dout`.
- Reset mid-burst drops the burst immediately. No partial write occurs because `ram_we` is forced low.
- `dbg_lock` deassertion mid-burst hands the grant to a waiting CPU in the same cycle.

## Structure
- Shared package: owner encoding constants (`OWN_IDLE`=2'd0, `OWN_CPU`=2'd1, `OWN_DBG`=2'd2) and the `stall_cnt` width.
- No sub-module, with one exception: `stall_cnt` as a reusable `sat_counter` (width parameter, enable, async active-low reset).

## Test plan
- Reset, then CPU-only stores/loads to address 10'h3 of 32'hDEADBEEF → `cpu_stall`=0 throughout, read returns 32'hDEADBEEF, `stall_cnt`=0.
- Both request, `owner`=IDLE, `dbg_lock`=0 → cycle 1 DBG granted (`cpu_stall`=1); cycle 2 CPU granted; `stall_cnt`=1.
- Both request continuously, `dbg_lock`=1, MAX_BURST=4 → DBG granted 4 cycles, CPU cycle 5, DBG cycle 6; `stall_cnt`=4 after cycle 5.
- Simultaneous writes: DBG writes 32'h1 to addr 5 and CPU writes 32'h2 to addr 5, both requesting, `owner`=IDLE → RAM holds 32'h1 after cycle 1 and 32'h2 after cycle 2.
- `rst_n` pulsed low during a locked burst at `burst_cnt`=2 → `ram_we`=0 and `cpu_stall`=1 immediately; after release the first contention goes to DBG with `burst_cnt` restarting at 0.
- Force 70000 stall cycles → `stall_cnt` saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: owner encoding and stall counter width.
// Pure declarations: no latency, no backpressure.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// One-cycle update latency; the enable is the only flow control.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU load/store path and the debug port.
// Zero-latency grant and mux; a losing CPU is held via cpu_stall, debug just sees no dbg_gnt.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_stall,
  input  logic                   dbg_req,
  input  logic                   dbg_we,
  input  logic                   dbg_lock,
  input  logic [ADDR_W-1:0]      dbg_addr,
  input  logic [DATA_W-1:0]      dbg_wdata,
  output logic [DATA_W-1:0]      dbg_rdata,
  output logic                   dbg_gnt,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_we,
  output logic [DATA_W-1:0]      ram_din,
  input  logic [DATA_W-1:0]      ram_dout,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  owner_e             owner_q;
  owner_e             owner_d;
  logic [BURST_W-1:0] burst_cnt_q;
  logic [BURST_W-1:0] burst_cnt_d;

  logic cpu_win;
  logic dbg_win;
  logic cpu_gnt;
  logic dbg_gnt_w;
  logic stall_en;

  // Under contention the debug port wins unless it already held the RAM last
  // cycle and has either dropped its lock or used up its burst allowance.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (cpu_req && dbg_req) begin
      if ((owner_q == OWN_DBG) && !(dbg_lock && (burst_cnt_q < BURST_MAX))) begin
        cpu_win = 1'b1;
      end else begin
        dbg_win = 1'b1;
      end
    end else begin
      cpu_win = cpu_req;
      dbg_win = dbg_req;
    end
    cpu_gnt   = cpu_win & rst_n;
    dbg_gnt_w = dbg_win & rst_n;
  end

  // Reset freezes the PC regardless of cpu_req.
  assign cpu_stall = ~rst_n | (cpu_req & ~cpu_gnt);
  assign dbg_gnt   = dbg_gnt_w;
  assign cpu_rdata = ram_dout;
  assign dbg_rdata = ram_dout;

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_wdata;
    ram_we   = 1'b0;
    if (dbg_gnt_w) begin
      ram_addr = dbg_addr;
      ram_din  = dbg_wdata;
      ram_we   = dbg_we;
    end else if (cpu_gnt) begin
      ram_we   = cpu_we;
    end
  end

  always_comb begin
    owner_d     = OWN_IDLE;
    burst_cnt_d = '0;
    if (dbg_gnt_w) begin
      owner_d     = OWN_DBG;
      burst_cnt_d = burst_cnt_q;
      // Only grants that keep the CPU waiting use up the burst allowance.
      if (cpu_req && (burst_cnt_q < BURST_MAX)) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end
    end else if (cpu_gnt) begin
      owner_d = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_IDLE;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign stall_en = cpu_stall & rst_n;

  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (stall_en),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a rule-level reference model.
// A second instance with a long burst allowance drives the stall counter into saturation.
module tb_dmem_arbiter;

  localparam int M     = 4;
  localparam int M_SAT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [9:0]  cpu_addr, dbg_addr, ram_addr;
  logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, ram_din, ram_dout;
  logic        cpu_stall, dbg_gnt, ram_we;
  logic [15:0] stall_cnt;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(M)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_gnt(dbg_gnt),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .stall_cnt(stall_cnt)
  );

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr];

  // Saturation instance: permanent contention with lock held.
  logic        rst_n_sat;
  logic [9:0]  s2_addr;
  logic [31:0] s2_rdc, s2_rdd, s2_din;
  logic        s2_stall, s2_gnt, s2_we;
  logic [15:0] s2_cnt;
  int          sat_cyc = 0;
  bit          sat_done = 0;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(M_SAT)) u_sat (
    .clk(clk), .rst_n(rst_n_sat),
    .cpu_req(1'b1), .cpu_we(1'b0), .cpu_addr(10'h0), .cpu_wdata(32'h0),
    .cpu_rdata(s2_rdc), .cpu_stall(s2_stall),
    .dbg_req(1'b1), .dbg_we(1'b0), .dbg_lock(1'b1), .dbg_addr(10'h1),
    .dbg_wdata(32'h0), .dbg_rdata(s2_rdd), .dbg_gnt(s2_gnt),
    .ram_addr(s2_addr), .ram_we(s2_we), .ram_din(s2_din), .ram_dout(32'h0),
    .stall_cnt(s2_cnt)
  );

  always @(posedge clk) if (rst_n_sat) sat_cyc <= sat_cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who held the RAM last, how many debug grants in a row
  // have kept the CPU waiting, and how many stalled cycles so far.
  int          m_last;   // 0 nobody, 1 cpu, 2 dbg
  int          m_run;
  int          m_stall;
  logic        e_cpu, e_dbg, e_we, e_stall;
  logic [9:0]  e_addr;
  logic [31:0] e_din;
  logic        s_stall, s_gnt;
  logic [31:0] s_cpu_rd;

  task automatic model_reset();
    m_last = 0; m_run = 0; m_stall = 0;
  endtask

  task automatic check_now();
    e_cpu = 1'b0; e_dbg = 1'b0;
    if (cpu_req && dbg_req) begin
      if (m_last != 2 || (dbg_lock && m_run < M)) e_dbg = 1'b1;
      else e_cpu = 1'b1;
    end else begin
      e_cpu = cpu_req; e_dbg = dbg_req;
    end
    e_stall = cpu_req && !e_cpu;
    e_addr  = e_dbg ? dbg_addr : cpu_addr;
    e_din   = e_dbg ? dbg_wdata : cpu_wdata;
    e_we    = e_dbg ? dbg_we : (e_cpu ? cpu_we : 1'b0);
    s_stall = cpu_stall; s_gnt = dbg_gnt; s_cpu_rd = cpu_rdata;
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("dbg_gnt",   32'(dbg_gnt),   32'(e_dbg));
    chk("ram_we",    32'(ram_we),    32'(e_we));
    chk("ram_addr",  32'(ram_addr),  32'(e_addr));
    chk("ram_din",   ram_din,        e_din);
    chk("cpu_rdata", cpu_rdata,      ref_mem[e_addr]);
    chk("dbg_rdata", dbg_rdata,      ref_mem[e_addr]);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic advance();
    @(posedge clk);
    if (e_we) ref_mem[e_addr] = e_din;
    if (e_dbg) begin
      if (cpu_req && m_run < M) m_run++;
      m_last = 2;
    end else begin
      m_run  = 0;
      m_last = e_cpu ? 1 : 0;
    end
    if (e_stall && m_stall < 65535) m_stall++;
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_now();
    advance();
  endtask

  // Entered just after a rising edge; the first cycle after release is checked too.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ram_we",    32'(ram_we),    32'h0);
    chk("rst_dbg_gnt",   32'(dbg_gnt),   32'h0);
    chk("rst_cpu_stall", 32'(cpu_stall), 32'h1);
    chk("rst_cpu_rdata", cpu_rdata,      mem[ram_addr]);
    chk("rst_dbg_rdata", dbg_rdata,      mem[ram_addr]);
    @(negedge clk);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_now();
    advance();
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  function automatic int exp_sat(input int n);
    int v;
    v = n - n / (M_SAT + 1);
    return (v > 65535) ? 65535 : v;
  endfunction

  initial begin
    int tgt [4];
    tgt = '{1000, 65000, 70300, 70400};
    rst_n_sat = 1'b0;
    repeat (2) @(negedge clk);
    rst_n_sat = 1'b1;
    foreach (tgt[i]) begin
      while (sat_cyc < tgt[i]) @(negedge clk);
      chk("sat_stall_cnt", 32'(s2_cnt), 32'(exp_sat(tgt[i])));
    end
    sat_done = 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_run;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // CPU-only store then load
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h3; cpu_wdata = 32'hDEADBEEF;
    cycle();
    chk("t1_store_stall", 32'(s_stall), 32'h0);
    cpu_we = 0;
    cycle();
    chk("t1_load_stall", 32'(s_stall), 32'h0);
    chk("t1_load_data", s_cpu_rd, 32'hDEADBEEF);
    chk("t1_stall_cnt", 32'(stall_cnt), 32'h0);

    // Contention from idle, unlocked
    idle_inputs();
    do_reset();
    cpu_req = 1; dbg_req = 1; cpu_addr = 10'h3; dbg_addr = 10'h4;
    cycle();
    chk("t2_c1_stall", 32'(s_stall), 32'h1);
    chk("t2_c1_gnt",   32'(s_gnt),   32'h1);
    cycle();
    chk("t2_c2_stall", 32'(s_stall), 32'h0);
    chk("t2_c2_gnt",   32'(s_gnt),   32'h0);
    chk("t2_stall_cnt", 32'(stall_cnt), 32'h1);

    // Locked burst capped at M, then CPU, then debug again
    idle_inputs();
    do_reset();
    cpu_req = 1; dbg_req = 1; dbg_lock = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t3_burst_gnt", 32'(s_gnt), (i == 4) ? 32'h0 : 32'h1);
      if (i == 4) chk("t3_stall_cnt", 32'(stall_cnt), 32'h4);
    end

    // Same-address writes: debug first, CPU second
    idle_inputs();
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'h5; cpu_wdata = 32'h2;
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h5; dbg_wdata = 32'h1;
    cycle();
    chk("t4_mem_after_c1", mem[5], 32'h1);
    cycle();
    chk("t4_mem_after_c2", mem[5], 32'h2);

    // Reset in the middle of a locked debug write burst
    idle_inputs();
    do_reset();
    cpu_req = 1; cpu_addr = 10'h9; dbg_req = 1; dbg_lock = 1;
    dbg_we = 1; dbg_addr = 10'h7; dbg_wdata = 32'hA5A5_0001;
    cycle();
    cycle();
    do_reset();
    chk("t5_first_after_rst", 32'(s_gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_burst_restart", 32'(s_gnt), (i == 3) ? 32'h0 : 32'h1);
    end

    // Randomized traffic; a stalled CPU keeps presenting the same request
    idle_inputs();
    do_reset();
    wait_run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!s_stall) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = 10'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      dbg_req   = ($urandom_range(0, 2) != 0);
      dbg_we    = $urandom_range(0, 1) == 1;
      dbg_lock  = ($urandom_range(0, 3) != 0);
      dbg_addr  = 10'($urandom_range(0, 15));
      dbg_wdata = $urandom;
      cycle();
      if (s_stall) begin
        wait_run++;
      end else begin
        if (wait_run > 0) chk("cpu_wait_bound", 32'(wait_run <= M), 32'h1);
        wait_run = 0;
      end
    end

    idle_inputs();
    while (!sat_done) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
